// File: rtl/udma_pkg.sv
// Shared types and register map for the hyper config block.
// Register offsets are word addresses; CFG/STATUS bit positions are shared by RTL and bench.
package udma_pkg;

    typedef struct packed {
        logic [31:0] data;
        logic [5:0]  addr;
        logic        valid;
        logic        rwn;
    } cfg_req_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] data;
    } cfg_rsp_t;

    localparam logic [5:0] REG_RX_SADDR = 6'h00;
    localparam logic [5:0] REG_RX_SIZE  = 6'h01;
    localparam logic [5:0] REG_RX_CFG   = 6'h02;
    localparam logic [5:0] REG_TX_SADDR = 6'h04;
    localparam logic [5:0] REG_TX_SIZE  = 6'h05;
    localparam logic [5:0] REG_TX_CFG   = 6'h06;
    localparam logic [5:0] REG_EXT_ADDR = 6'h08;
    localparam logic [5:0] REG_STATUS   = 6'h0A;

    // Offsets inside a channel window (addr[1:0])
    localparam logic [1:0] CH_OFF_SADDR = 2'd0;
    localparam logic [1:0] CH_OFF_SIZE  = 2'd1;
    localparam logic [1:0] CH_OFF_CFG   = 2'd2;

    localparam int unsigned CFG_DSIZE_LSB = 0;
    localparam int unsigned CFG_DSIZE_W   = 2;
    localparam int unsigned CFG_CONT_BIT  = 4;
    localparam int unsigned CFG_EN_BIT    = 5;
    localparam int unsigned CFG_CLR_BIT   = 6;
    localparam int unsigned CFG_PEND_BIT  = 6;

    localparam int unsigned STAT_VALID_BIT  = 0;
    localparam int unsigned STAT_RXERR_BIT  = 1;
    localparam int unsigned STAT_TXERR_BIT  = 2;
    localparam int unsigned STAT_ERRCLR_BIT = 31;

endpackage

// File: rtl/hyper_cfg_ctrl_if.sv
// Per-channel link between a config channel and the uDMA core.
// master = config side, slave = uDMA core side.
interface hyper_cfg_ctrl_if #(
    parameter int unsigned L2_AWIDTH  = 19,
    parameter int unsigned TRANS_SIZE = 20
);
    logic [L2_AWIDTH-1:0]  startaddr;
    logic [TRANS_SIZE-1:0] size;
    logic [1:0]            datasize;
    logic                  continuous;
    logic                  req;
    logic                  clr;
    logic                  en;
    logic                  pending;
    logic [L2_AWIDTH-1:0]  curr_addr;
    logic [TRANS_SIZE-1:0] bytes_left;

    modport master (
        output startaddr, size, datasize, continuous, req, clr,
        input  en, pending, curr_addr, bytes_left
    );

    modport slave (
        input  startaddr, size, datasize, continuous, req, clr,
        output en, pending, curr_addr, bytes_left
    );
endinterface

// File: rtl/hyper_cfg_ch.sv
// One uDMA channel: SADDR/SIZE/CFG registers, req/clr pulses and done event.
// HYPER_CFG_ERR_EN adds the sticky drop error and an event on a dropped EN write.
module hyper_cfg_ch
    import udma_pkg::*;
#(
    parameter int unsigned L2_AWIDTH  = 19,
    parameter int unsigned TRANS_SIZE = 20
) (
    input  logic             i_clk,
    input  logic             i_rst,
    hyper_cfg_ctrl_if.master ch_if,
    input  logic             i_sel,
    input  logic             i_wr,
    input  logic [1:0]       i_off,
    input  logic [31:0]      i_wdata,
    input  logic             i_busy,
`ifdef HYPER_CFG_ERR_EN
    input  logic             i_err_clr,
    output logic             o_err,
`endif
    output logic             o_start_c,
    output logic [31:0]      o_rdata_c,
    output logic             o_evt
);

    logic [L2_AWIDTH-1:0]   r_saddr;
    logic [TRANS_SIZE-1:0]  r_size;
    logic [CFG_DSIZE_W-1:0] r_dsize;
    logic                   r_cont;
    logic                   r_req_arm;
    logic                   r_clr_arm;
    logic                   r_req;
    logic                   r_clr;
    logic                   r_en_d;
    logic                   r_evt;
    logic                   w_cfg_wr;
    logic                   w_en_wr;
    logic                   w_drop;
    logic                   w_drop_evt;
    logic                   w_unused;

    // CLR wins over EN; an EN write is only accepted when the PHY command slot and channel are free
    assign w_cfg_wr  = i_sel & i_wr & (i_off == CH_OFF_CFG);
    assign w_en_wr   = w_cfg_wr & i_wdata[CFG_EN_BIT] & ~i_wdata[CFG_CLR_BIT];
    assign o_start_c = w_en_wr & ~i_busy & ~ch_if.pending;
    assign w_drop    = w_en_wr & (i_busy | ch_if.pending);
    assign w_unused  = ^{i_wdata, w_drop};

    // req/clr are armed on the write edge and fire one cycle later, after the ACK cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_saddr   <= '0;
            r_size    <= '0;
            r_dsize   <= '0;
            r_cont    <= 1'b0;
            r_req_arm <= 1'b0;
            r_clr_arm <= 1'b0;
            r_req     <= 1'b0;
            r_clr     <= 1'b0;
            r_en_d    <= 1'b0;
            r_evt     <= 1'b0;
        end else begin
            if (i_sel && i_wr && (i_off == CH_OFF_SADDR)) begin
                r_saddr <= L2_AWIDTH'(i_wdata);
            end
            if (i_sel && i_wr && (i_off == CH_OFF_SIZE)) begin
                r_size <= TRANS_SIZE'(i_wdata);
            end
            if (w_cfg_wr) begin
                r_dsize <= i_wdata[CFG_DSIZE_LSB +: CFG_DSIZE_W];
                r_cont  <= i_wdata[CFG_CONT_BIT];
            end
            r_req_arm <= o_start_c;
            r_clr_arm <= w_cfg_wr & i_wdata[CFG_CLR_BIT];
            r_req     <= r_req_arm;
            r_clr     <= r_clr_arm;
            r_en_d    <= ch_if.en;
            r_evt     <= (r_en_d & ~ch_if.en) | w_drop_evt;
        end
    end

`ifdef HYPER_CFG_ERR_EN
    logic r_err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (w_drop) begin
            r_err <= 1'b1;
        end else if (i_err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign o_err      = r_err;
    assign w_drop_evt = w_drop;
`else
    assign w_drop_evt = 1'b0;
`endif

    // Readback: address/size reflect live core progress, CFG mixes stored and live bits
    always_comb begin
        o_rdata_c = '0;
        case (i_off)
            CH_OFF_SADDR: o_rdata_c = 32'(ch_if.curr_addr);
            CH_OFF_SIZE:  o_rdata_c = 32'(ch_if.bytes_left);
            CH_OFF_CFG: begin
                o_rdata_c[CFG_DSIZE_LSB +: CFG_DSIZE_W] = r_dsize;
                o_rdata_c[CFG_CONT_BIT]                 = r_cont;
                o_rdata_c[CFG_EN_BIT]                   = ch_if.en;
                o_rdata_c[CFG_PEND_BIT]                 = ch_if.pending;
            end
            default: o_rdata_c = '0;
        endcase
    end

    assign ch_if.startaddr  = r_saddr;
    assign ch_if.size       = r_size;
    assign ch_if.datasize   = r_dsize;
    assign ch_if.continuous = r_cont;
    assign ch_if.req        = r_req;
    assign ch_if.clr        = r_clr;
    assign o_evt            = r_evt;

endmodule

// File: rtl/hyper_cfg_ctrl.sv
// HyperBus uDMA config controller: register access FSM, RX/TX channels and PHY command.
// Build option HYPER_CFG_ERR_EN enables sticky drop errors in STATUS[2:1].
module hyper_cfg_ctrl
    import udma_pkg::*;
#(
    parameter int unsigned L2_AWIDTH  = 19,
    parameter int unsigned TRANS_SIZE = 20
) (
    input  logic                  sys_clk_i,
    input  logic                  rst_i,
    input  cfg_req_t              cfg_req_i,
    output cfg_rsp_t              cfg_rsp_o,
    output logic [L2_AWIDTH-1:0]  rx_startaddr_o,
    output logic [TRANS_SIZE-1:0] rx_size_o,
    output logic [1:0]            rx_datasize_o,
    output logic                  rx_continuous_o,
    output logic                  rx_req_o,
    output logic                  rx_clr_o,
    input  logic                  rx_en_i,
    input  logic                  rx_pending_i,
    input  logic [L2_AWIDTH-1:0]  rx_curr_addr_i,
    input  logic [TRANS_SIZE-1:0] rx_bytes_left_i,
    output logic [L2_AWIDTH-1:0]  tx_startaddr_o,
    output logic [TRANS_SIZE-1:0] tx_size_o,
    output logic [1:0]            tx_datasize_o,
    output logic                  tx_continuous_o,
    output logic                  tx_req_o,
    output logic                  tx_clr_o,
    input  logic                  tx_en_i,
    input  logic                  tx_pending_i,
    input  logic [L2_AWIDTH-1:0]  tx_curr_addr_i,
    input  logic [TRANS_SIZE-1:0] tx_bytes_left_i,
    output logic                  trans_valid_o,
    input  logic                  trans_ready_i,
    output logic                  trans_rwn_o,
    output logic [31:0]           trans_addr_o,
    output logic [TRANS_SIZE-1:0] trans_size_o,
    output logic [1:0]            evt_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK  = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic                  w_access;
    logic                  w_wr;
    logic                  w_rx_sel;
    logic                  w_tx_sel;
    logic                  w_rx_start;
    logic                  w_tx_start;
    logic                  w_rx_evt;
    logic                  w_tx_evt;
    logic                  w_rx_err;
    logic                  w_tx_err;
    logic [31:0]           w_rx_rdata;
    logic [31:0]           w_tx_rdata;
    logic [31:0]           w_rdata;
    logic [31:0]           r_ext_addr;
    cfg_rsp_t              r_rsp;
    logic                  r_trans_valid;
    logic                  r_trans_rwn;
    logic [31:0]           r_trans_addr;
    logic [TRANS_SIZE-1:0] r_trans_size;

    hyper_cfg_ctrl_if #(.L2_AWIDTH(L2_AWIDTH), .TRANS_SIZE(TRANS_SIZE)) u_rx_if ();
    hyper_cfg_ctrl_if #(.L2_AWIDTH(L2_AWIDTH), .TRANS_SIZE(TRANS_SIZE)) u_tx_if ();

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Access is taken on the IDLE->ACK edge; ACK always lasts one cycle
    always_comb begin
        w_state_nxt = r_state;
        w_access    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cfg_req_i.valid) begin
                    w_state_nxt = ST_ACK;
                    w_access    = 1'b1;
                end
            end
            ST_ACK:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_wr     = w_access & ~cfg_req_i.rwn;
    assign w_rx_sel = (cfg_req_i.addr[5:2] == REG_RX_SADDR[5:2]);
    assign w_tx_sel = (cfg_req_i.addr[5:2] == REG_TX_SADDR[5:2]);

`ifdef HYPER_CFG_ERR_EN
    logic w_err_clr;
    assign w_err_clr = w_wr & (cfg_req_i.addr == REG_STATUS) & cfg_req_i.data[STAT_ERRCLR_BIT];
`else
    assign w_rx_err = 1'b0;
    assign w_tx_err = 1'b0;
`endif

    hyper_cfg_ch #(.L2_AWIDTH(L2_AWIDTH), .TRANS_SIZE(TRANS_SIZE)) u_rx_ch (
        .i_clk     (sys_clk_i),
        .i_rst     (rst_i),
        .ch_if     (u_rx_if),
        .i_sel     (w_rx_sel),
        .i_wr      (w_wr),
        .i_off     (cfg_req_i.addr[1:0]),
        .i_wdata   (cfg_req_i.data),
        .i_busy    (r_trans_valid),
`ifdef HYPER_CFG_ERR_EN
        .i_err_clr (w_err_clr),
        .o_err     (w_rx_err),
`endif
        .o_start_c (w_rx_start),
        .o_rdata_c (w_rx_rdata),
        .o_evt     (w_rx_evt)
    );

    hyper_cfg_ch #(.L2_AWIDTH(L2_AWIDTH), .TRANS_SIZE(TRANS_SIZE)) u_tx_ch (
        .i_clk     (sys_clk_i),
        .i_rst     (rst_i),
        .ch_if     (u_tx_if),
        .i_sel     (w_tx_sel),
        .i_wr      (w_wr),
        .i_off     (cfg_req_i.addr[1:0]),
        .i_wdata   (cfg_req_i.data),
        .i_busy    (r_trans_valid),
`ifdef HYPER_CFG_ERR_EN
        .i_err_clr (w_err_clr),
        .o_err     (w_tx_err),
`endif
        .o_start_c (w_tx_start),
        .o_rdata_c (w_tx_rdata),
        .o_evt     (w_tx_evt)
    );

    // Read mux; anything outside the map (incl. addr[5]=1) reads as zero
    always_comb begin
        w_rdata = '0;
        if (w_rx_sel) begin
            w_rdata = w_rx_rdata;
        end else if (w_tx_sel) begin
            w_rdata = w_tx_rdata;
        end else if (cfg_req_i.addr == REG_EXT_ADDR) begin
            w_rdata = r_ext_addr;
        end else if (cfg_req_i.addr == REG_STATUS) begin
            w_rdata[STAT_VALID_BIT] = r_trans_valid;
            w_rdata[STAT_RXERR_BIT] = w_rx_err;
            w_rdata[STAT_TXERR_BIT] = w_tx_err;
        end
    end

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rsp      <= '0;
            r_ext_addr <= '0;
        end else begin
            r_rsp.ready <= w_access;
            r_rsp.data  <= (w_access && cfg_req_i.rwn) ? w_rdata : '0;
            if (w_wr && (cfg_req_i.addr == REG_EXT_ADDR)) begin
                r_ext_addr <= cfg_req_i.data;
            end
        end
    end

    // Single PHY command slot, held until the PHY accepts it
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_trans_valid <= 1'b0;
            r_trans_rwn   <= 1'b0;
            r_trans_addr  <= '0;
            r_trans_size  <= '0;
        end else if (w_rx_start) begin
            r_trans_valid <= 1'b1;
            r_trans_rwn   <= 1'b1;
            r_trans_addr  <= r_ext_addr;
            r_trans_size  <= u_rx_if.size;
        end else if (w_tx_start) begin
            r_trans_valid <= 1'b1;
            r_trans_rwn   <= 1'b0;
            r_trans_addr  <= r_ext_addr;
            r_trans_size  <= u_tx_if.size;
        end else if (r_trans_valid && trans_ready_i) begin
            r_trans_valid <= 1'b0;
        end
    end

    assign u_rx_if.en         = rx_en_i;
    assign u_rx_if.pending    = rx_pending_i;
    assign u_rx_if.curr_addr  = rx_curr_addr_i;
    assign u_rx_if.bytes_left = rx_bytes_left_i;
    assign u_tx_if.en         = tx_en_i;
    assign u_tx_if.pending    = tx_pending_i;
    assign u_tx_if.curr_addr  = tx_curr_addr_i;
    assign u_tx_if.bytes_left = tx_bytes_left_i;

    assign rx_startaddr_o  = u_rx_if.startaddr;
    assign rx_size_o       = u_rx_if.size;
    assign rx_datasize_o   = u_rx_if.datasize;
    assign rx_continuous_o = u_rx_if.continuous;
    assign rx_req_o        = u_rx_if.req;
    assign rx_clr_o        = u_rx_if.clr;
    assign tx_startaddr_o  = u_tx_if.startaddr;
    assign tx_size_o       = u_tx_if.size;
    assign tx_datasize_o   = u_tx_if.datasize;
    assign tx_continuous_o = u_tx_if.continuous;
    assign tx_req_o        = u_tx_if.req;
    assign tx_clr_o        = u_tx_if.clr;

    assign cfg_rsp_o     = r_rsp;
    assign trans_valid_o = r_trans_valid;
    assign trans_rwn_o   = r_trans_rwn;
    assign trans_addr_o  = r_trans_addr;
    assign trans_size_o  = r_trans_size;
    assign evt_o         = {w_tx_evt, w_rx_evt};

endmodule

// File: tb/tb_hyper_cfg_ctrl.sv
// Directed self-checking bench for hyper_cfg_ctrl; expectations follow HYPER_CFG_ERR_EN.
module tb_hyper_cfg_ctrl;
    import udma_pkg::*;

    localparam int unsigned L2_AWIDTH  = 19;
    localparam int unsigned TRANS_SIZE = 20;

`ifdef HYPER_CFG_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    cfg_req_t              cfg_req;
    cfg_rsp_t              cfg_rsp;
    logic                  trans_valid;
    logic                  trans_ready;
    logic                  trans_rwn;
    logic [31:0]           trans_addr;
    logic [TRANS_SIZE-1:0] trans_size;
    logic [1:0]            evt;

    hyper_cfg_ctrl_if #(.L2_AWIDTH(L2_AWIDTH), .TRANS_SIZE(TRANS_SIZE)) rx_if ();
    hyper_cfg_ctrl_if #(.L2_AWIDTH(L2_AWIDTH), .TRANS_SIZE(TRANS_SIZE)) tx_if ();

    hyper_cfg_ctrl #(.L2_AWIDTH(L2_AWIDTH), .TRANS_SIZE(TRANS_SIZE)) dut (
        .sys_clk_i       (clk),
        .rst_i           (rst),
        .cfg_req_i       (cfg_req),
        .cfg_rsp_o       (cfg_rsp),
        .rx_startaddr_o  (rx_if.startaddr),
        .rx_size_o       (rx_if.size),
        .rx_datasize_o   (rx_if.datasize),
        .rx_continuous_o (rx_if.continuous),
        .rx_req_o        (rx_if.req),
        .rx_clr_o        (rx_if.clr),
        .rx_en_i         (rx_if.en),
        .rx_pending_i    (rx_if.pending),
        .rx_curr_addr_i  (rx_if.curr_addr),
        .rx_bytes_left_i (rx_if.bytes_left),
        .tx_startaddr_o  (tx_if.startaddr),
        .tx_size_o       (tx_if.size),
        .tx_datasize_o   (tx_if.datasize),
        .tx_continuous_o (tx_if.continuous),
        .tx_req_o        (tx_if.req),
        .tx_clr_o        (tx_if.clr),
        .tx_en_i         (tx_if.en),
        .tx_pending_i    (tx_if.pending),
        .tx_curr_addr_i  (tx_if.curr_addr),
        .tx_bytes_left_i (tx_if.bytes_left),
        .trans_valid_o   (trans_valid),
        .trans_ready_i   (trans_ready),
        .trans_rwn_o     (trans_rwn),
        .trans_addr_o    (trans_addr),
        .trans_size_o    (trans_size),
        .evt_o           (evt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_rx_req = 0, n_tx_req = 0, n_rx_clr = 0, n_ready = 0, n_evt_rx = 0, n_evt_tx = 0;

    // Pulse counters for one-shot outputs
    always @(posedge clk) begin
        if (rx_if.req)     n_rx_req++;
        if (tx_if.req)     n_tx_req++;
        if (rx_if.clr)     n_rx_clr++;
        if (cfg_rsp.ready) n_ready++;
        if (evt[0])        n_evt_rx++;
        if (evt[1])        n_evt_tx++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access: latency must be exactly one cycle, then ready must drop
    task automatic cfg_access(input logic rwn, input logic [5:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata);
        int lat;
        cfg_req.valid = 1'b1;
        cfg_req.rwn   = rwn;
        cfg_req.addr  = addr;
        cfg_req.data  = wdata;
        lat   = 0;
        rdata = '0;
        do begin
            tick();
            lat++;
        end while (!cfg_rsp.ready && lat < 8);
        check("acc_latency", 32'(lat), 32'd1);
        rdata = cfg_rsp.data;
        cfg_req.valid = 1'b0;
        tick();
        check("ready_one_cycle", 32'(cfg_rsp.ready), 32'd0);
    endtask

    task automatic cfg_wr(input logic [5:0] addr, input logic [31:0] wdata);
        logic [31:0] dummy;
        cfg_access(1'b0, addr, wdata, dummy);
    endtask

    task automatic cfg_rd_chk(input string tag, input logic [5:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        cfg_access(1'b1, addr, 32'h0, rd);
        check(tag, rd, exp);
    endtask

    initial begin
        int b_req, b_tx, b_clr, b_evt, b_rdy;
        cfg_req          = '0;
        rst              = 1'b1;
        trans_ready      = 1'b0;
        rx_if.en         = 1'b0;
        rx_if.pending    = 1'b0;
        rx_if.curr_addr  = 19'h01234;
        rx_if.bytes_left = 20'hABCDE;
        tx_if.en         = 1'b0;
        tx_if.pending    = 1'b0;
        tx_if.curr_addr  = 19'h7FFFF;
        tx_if.bytes_left = 20'h00010;
        repeat (3) tick();
        check("rst_ready", 32'(cfg_rsp.ready), 32'd0);
        check("rst_data", cfg_rsp.data, 32'd0);
        check("rst_tvalid", 32'(trans_valid), 32'd0);
        check("rst_evt", 32'(evt), 32'd0);
        check("rst_rx_req", 32'(rx_if.req), 32'd0);
        rst = 1'b0;
        tick();

        // Basic register writes and readback
        cfg_wr(REG_RX_SADDR, 32'h100);
        cfg_wr(REG_RX_SIZE, 32'd64);
        cfg_wr(REG_EXT_ADDR, 32'h2000);
        check("rx_startaddr", 32'(rx_if.startaddr), 32'h100);
        check("rx_size", 32'(rx_if.size), 32'd64);
        cfg_rd_chk("rd_ext_addr", REG_EXT_ADDR, 32'h2000);
        cfg_rd_chk("rd_rx_saddr", REG_RX_SADDR, 32'h1234);
        cfg_rd_chk("rd_rx_size", REG_RX_SIZE, 32'hABCDE);
        cfg_rd_chk("rd_tx_saddr", REG_TX_SADDR, 32'h7FFFF);

        // Unmapped and upper bank accesses
        cfg_wr(6'h28, 32'hDEAD);
        cfg_rd_chk("rd_ext_after_alias", REG_EXT_ADDR, 32'h2000);
        cfg_rd_chk("rd_bank1", 6'h28, 32'h0);
        cfg_rd_chk("rd_hole", 6'h03, 32'h0);

        // RX start
        b_req = n_rx_req;
        cfg_wr(REG_RX_CFG, 32'h22);
        check("rx_req_pulse", 32'(rx_if.req), 32'd1);
        check("tvalid_rx", 32'(trans_valid), 32'd1);
        check("trwn_rx", 32'(trans_rwn), 32'd1);
        check("taddr_rx", trans_addr, 32'h2000);
        check("tsize_rx", 32'(trans_size), 32'd64);
        check("rx_datasize", 32'(rx_if.datasize), 32'd2);
        tick();
        check("rx_req_end", 32'(rx_if.req), 32'd0);

        // TX EN while command outstanding is dropped
        b_tx  = n_tx_req;
        b_evt = n_evt_tx;
        cfg_wr(REG_TX_CFG, 32'h20);
        tick();
        tick();
        check("tx_drop_noreq", 32'(n_tx_req - b_tx), 32'd0);
        check("tx_drop_evt", 32'(n_evt_tx - b_evt), ERR_EN ? 32'd1 : 32'd0);
        check("trwn_kept", 32'(trans_rwn), 32'd1);
        cfg_rd_chk("status_busy", REG_STATUS, ERR_EN ? 32'h5 : 32'h1);

        // Command holds while PHY not ready, clears after handshake
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(trans_valid), 32'd1);
            check("hold_addr", trans_addr, 32'h2000);
            check("hold_size", 32'(trans_size), 32'd64);
            tick();
        end
        trans_ready = 1'b1;
        tick();
        trans_ready = 1'b0;
        check("tvalid_cleared", 32'(trans_valid), 32'd0);
        check("rx_req_once", 32'(n_rx_req - b_req), 32'd1);
        cfg_rd_chk("status_idle", REG_STATUS, ERR_EN ? 32'h4 : 32'h0);
        cfg_wr(REG_STATUS, 32'h8000_0000);
        cfg_rd_chk("status_errclr", REG_STATUS, 32'h0);

        // CLR has priority over EN
        b_req = n_rx_req;
        b_clr = n_rx_clr;
        cfg_wr(REG_RX_CFG, 32'h60);
        check("rx_clr_pulse", 32'(rx_if.clr), 32'd1);
        check("clr_no_cmd", 32'(trans_valid), 32'd0);
        tick();
        check("rx_clr_end", 32'(rx_if.clr), 32'd0);
        check("clr_count", 32'(n_rx_clr - b_clr), 32'd1);
        check("clr_noreq", 32'(n_rx_req - b_req), 32'd0);

        // EN while channel pending is dropped
        rx_if.pending = 1'b1;
        rx_if.en      = 1'b1;
        b_evt = n_evt_rx;
        cfg_wr(REG_RX_CFG, 32'h20);
        tick();
        check("pend_noreq", 32'(n_rx_req - b_req), 32'd0);
        check("pend_no_cmd", 32'(trans_valid), 32'd0);
        cfg_rd_chk("rd_rx_cfg", REG_RX_CFG, 32'h60);
        cfg_rd_chk("status_rxerr", REG_STATUS, ERR_EN ? 32'h2 : 32'h0);
        check("pend_evt", 32'(n_evt_rx - b_evt), ERR_EN ? 32'd1 : 32'd0);
        cfg_wr(REG_STATUS, 32'h8000_0000);

        // Simultaneous done on both channels
        rx_if.pending = 1'b0;
        tx_if.en      = 1'b1;
        tick();
        tick();
        rx_if.en = 1'b0;
        tx_if.en = 1'b0;
        tick();
        check("evt_both", 32'(evt), 32'h3);
        tick();
        check("evt_end", 32'(evt), 32'h0);

        // TX start
        cfg_wr(REG_TX_SIZE, 32'h30);
        cfg_wr(REG_TX_CFG, 32'h31);
        check("tx_req_pulse", 32'(tx_if.req), 32'd1);
        check("tvalid_tx", 32'(trans_valid), 32'd1);
        check("trwn_tx", 32'(trans_rwn), 32'd0);
        check("tsize_tx", 32'(trans_size), 32'h30);
        check("taddr_tx", trans_addr, 32'h2000);
        check("tx_cont", 32'(tx_if.continuous), 32'd1);
        check("tx_datasize", 32'(tx_if.datasize), 32'd1);
        tick();
        check("tx_req_end", 32'(tx_if.req), 32'd0);
        trans_ready = 1'b1;
        tick();
        trans_ready = 1'b0;
        check("tvalid_tx_cleared", 32'(trans_valid), 32'd0);

        // Reset during ACK of an accepted EN write
        b_req = n_rx_req;
        cfg_req.valid = 1'b1;
        cfg_req.rwn   = 1'b0;
        cfg_req.addr  = REG_RX_CFG;
        cfg_req.data  = 32'h22;
        tick();
        check("pre_rst_ready", 32'(cfg_rsp.ready), 32'd1);
        check("pre_rst_tvalid", 32'(trans_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_ready", 32'(cfg_rsp.ready), 32'd0);
        check("midrst_tvalid", 32'(trans_valid), 32'd0);
        check("midrst_evt", 32'(evt), 32'd0);
        check("midrst_rx_req", 32'(rx_if.req), 32'd0);
        b_rdy = n_ready;
        cfg_req.valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check("postrst_noready", 32'(n_ready - b_rdy), 32'd0);
        check("postrst_noreq", 32'(n_rx_req - b_req), 32'd0);
        check("postrst_tvalid", 32'(trans_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule
